// File: rtl/ex_ctrl_alu_pkg.sv
// rtl/ex_ctrl_alu_pkg.sv - shared encodings for the decode/execute slice
package ex_ctrl_alu_pkg;

  // Primary opcodes, inst[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes, inst[5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // 4-bit ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  // aluop encodings from main control to ALU control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADD2  = 2'b11;

  // Main-control bundle, field order matches the decode table
  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch_eq;
    logic       branch_ne;
    logic       jump;
    logic [1:0] aluop;
  } ctrl_t;

  // Map aluop/funct to the ALU operation; unknown funct falls back to add
  function automatic logic [3:0] alu_ctl_decode(input logic [1:0] aluop,
                                                input logic [5:0] funct);
    logic [3:0] op;
    op = ALU_ADD;
    case (aluop)
      ALUOP_ADD:   op = ALU_ADD;
      ALUOP_SUB:   op = ALU_SUB;
      ALUOP_ADD2:  op = ALU_ADD;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  op = ALU_ADD;
          FN_SUB:  op = ALU_SUB;
          FN_AND:  op = ALU_AND;
          FN_OR:   op = ALU_OR;
          FN_XOR:  op = ALU_XOR;
          FN_NOR:  op = ALU_NOR;
          FN_SLT:  op = ALU_SLT;
          default: op = ALU_ADD;
        endcase
      end
      default:     op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_ctrl_alu_if.sv
// rtl/ex_ctrl_alu_if.sv - instruction/operand inputs and control/ALU outputs of the slice
interface ex_ctrl_alu_if #(parameter int W = 32);

  // Stage inputs
  logic          flush;
  logic          hold;
  logic [31:0]   inst;
  logic [W-1:0]  rs_data;
  logic [W-1:0]  rt_data;

  // Combinational main control
  logic          regdst;
  logic          branch_eq;
  logic          branch_ne;
  logic          memread;
  logic          memwrite;
  logic          memtoreg;
  logic          regwrite;
  logic          alusrc;
  logic          jump;
  logic [1:0]    aluop;

  // Combinational ALU
  logic [3:0]    aluctl;
  logic [W-1:0]  alu_out;
  logic          zero;

  // Registered copies for the MEM stage
  logic [W-1:0]  alu_out_q;
  logic          zero_q;
  logic          regwrite_q;
  logic          memread_q;
  logic          memwrite_q;
  logic          memtoreg_q;

  // Upstream side: drives instruction and operands, observes results
  modport master (
    output flush, hold, inst, rs_data, rt_data,
    input  regdst, branch_eq, branch_ne, memread, memwrite, memtoreg,
           regwrite, alusrc, jump, aluop, aluctl, alu_out, zero,
           alu_out_q, zero_q, regwrite_q, memread_q, memwrite_q, memtoreg_q
  );

  // The execute slice itself
  modport slave (
    input  flush, hold, inst, rs_data, rt_data,
    output regdst, branch_eq, branch_ne, memread, memwrite, memtoreg,
           regwrite, alusrc, jump, aluop, aluctl, alu_out, zero,
           alu_out_q, zero_q, regwrite_q, memread_q, memwrite_q, memtoreg_q
  );

endinterface

// File: rtl/ex_ctrl_alu_alu_core.sv
// rtl/ex_ctrl_alu_alu_core.sv - pure combinational W-bit ALU with zero flag
module ex_ctrl_alu_alu_core
  import ex_ctrl_alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y,
  output logic         o_zero
);

  logic w_lt;

  assign w_lt = ($signed(i_a) < $signed(i_b));

  // Operation select; codes with no defined operation produce zero
  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_ADD: o_y = i_a + i_b;
      ALU_SUB: o_y = i_a - i_b;
      ALU_SLT: o_y = {{(W-1){1'b0}}, w_lt};
      ALU_NOR: o_y = ~(i_a | i_b);
      ALU_XOR: o_y = i_a ^ i_b;
      default: o_y = '0;
    endcase
  end

  assign o_zero = (o_y == '0);

endmodule

// File: rtl/ex_ctrl_alu.sv
// rtl/ex_ctrl_alu.sv - decode/execute slice: main control, ALU control, ALU and MEM-stage register
module ex_ctrl_alu
  import ex_ctrl_alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  ex_ctrl_alu_if.slave  bus
);

  logic [5:0]   w_opcode;
  logic [5:0]   w_funct;
  ctrl_t        w_ctrl;
  logic [3:0]   w_aluctl;
  logic [W-1:0] w_imm_ext;
  logic [W-1:0] w_opb;
  logic [W-1:0] w_alu_out;
  logic         w_zero;

  logic [W-1:0] r_alu_out_q;
  logic         r_zero_q;
  logic         r_regwrite_q;
  logic         r_memread_q;
  logic         r_memwrite_q;
  logic         r_memtoreg_q;

  assign w_opcode = bus.inst[31:26];
  assign w_funct  = bus.inst[5:0];

  // Main control decode; an all-zero word is a NOP even though it looks like R-type
  always_comb begin
    w_ctrl = '0;
    case (w_opcode)
      OP_RTYPE: begin
        if (bus.inst != 32'h0) begin
          w_ctrl.regdst   = 1'b1;
          w_ctrl.regwrite = 1'b1;
          w_ctrl.aluop    = ALUOP_FUNCT;
        end
      end
      OP_LW: begin
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.memtoreg = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.memread  = 1'b1;
        w_ctrl.aluop    = ALUOP_ADD;
      end
      OP_SW: begin
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.memwrite = 1'b1;
        w_ctrl.aluop    = ALUOP_ADD;
      end
      OP_ADDI: begin
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.aluop    = ALUOP_ADD;
      end
      OP_BEQ: begin
        w_ctrl.branch_eq = 1'b1;
        w_ctrl.aluop     = ALUOP_SUB;
      end
      OP_BNE: begin
        w_ctrl.branch_ne = 1'b1;
        w_ctrl.aluop     = ALUOP_SUB;
      end
      OP_J: begin
        w_ctrl.jump = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

  // ALU control from aluop and funct
  always_comb begin
    w_aluctl = alu_ctl_decode(w_ctrl.aluop, w_funct);
  end

  // Operand B: sign-extended immediate for memory/immediate ops, else register
  assign w_imm_ext = {{(W-16){bus.inst[15]}}, bus.inst[15:0]};
  assign w_opb     = w_ctrl.alusrc ? w_imm_ext : bus.rt_data;

  ex_ctrl_alu_alu_core #(
    .W (W)
  ) u_alu_core (
    .i_op   (w_aluctl),
    .i_a    (bus.rs_data),
    .i_b    (w_opb),
    .o_y    (w_alu_out),
    .o_zero (w_zero)
  );

  // MEM-stage register: flush inserts a bubble and beats hold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alu_out_q  <= '0;
      r_zero_q     <= 1'b0;
      r_regwrite_q <= 1'b0;
      r_memread_q  <= 1'b0;
      r_memwrite_q <= 1'b0;
      r_memtoreg_q <= 1'b0;
    end else if (bus.flush) begin
      r_alu_out_q  <= '0;
      r_zero_q     <= 1'b0;
      r_regwrite_q <= 1'b0;
      r_memread_q  <= 1'b0;
      r_memwrite_q <= 1'b0;
      r_memtoreg_q <= 1'b0;
    end else if (!bus.hold) begin
      r_alu_out_q  <= w_alu_out;
      r_zero_q     <= w_zero;
      r_regwrite_q <= w_ctrl.regwrite;
      r_memread_q  <= w_ctrl.memread;
      r_memwrite_q <= w_ctrl.memwrite;
      r_memtoreg_q <= w_ctrl.memtoreg;
    end
  end

  assign bus.regdst     = w_ctrl.regdst;
  assign bus.alusrc     = w_ctrl.alusrc;
  assign bus.memtoreg   = w_ctrl.memtoreg;
  assign bus.regwrite   = w_ctrl.regwrite;
  assign bus.memread    = w_ctrl.memread;
  assign bus.memwrite   = w_ctrl.memwrite;
  assign bus.branch_eq  = w_ctrl.branch_eq;
  assign bus.branch_ne  = w_ctrl.branch_ne;
  assign bus.jump       = w_ctrl.jump;
  assign bus.aluop      = w_ctrl.aluop;
  assign bus.aluctl     = w_aluctl;
  assign bus.alu_out    = w_alu_out;
  assign bus.zero       = w_zero;

  assign bus.alu_out_q  = r_alu_out_q;
  assign bus.zero_q     = r_zero_q;
  assign bus.regwrite_q = r_regwrite_q;
  assign bus.memread_q  = r_memread_q;
  assign bus.memwrite_q = r_memwrite_q;
  assign bus.memtoreg_q = r_memtoreg_q;

endmodule

// File: tb/tb_ex_ctrl_alu.sv
// tb/tb_ex_ctrl_alu.sv - directed-vector bench for ex_ctrl_alu
module tb_ex_ctrl_alu;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  ex_ctrl_alu_if #(.W(32)) bus_if ();

  ex_ctrl_alu #(.W(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {regdst,alusrc,memtoreg,regwrite,memread,memwrite,beq,bne,jump,aluop}
  function automatic logic [31:0] ctl();
    return {21'b0, bus_if.regdst, bus_if.alusrc, bus_if.memtoreg, bus_if.regwrite,
            bus_if.memread, bus_if.memwrite, bus_if.branch_eq, bus_if.branch_ne,
            bus_if.jump, bus_if.aluop};
  endfunction

  task automatic apply(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus_if.inst    = inst;
    bus_if.rs_data = a;
    bus_if.rt_data = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_if.flush   = 1'b0;
    bus_if.hold    = 1'b0;
    bus_if.inst    = 32'h0;
    bus_if.rs_data = 32'h0;
    bus_if.rt_data = 32'h0;

    #3;
    chk("rst_alu_out_q", bus_if.alu_out_q, 32'h0);
    chk("rst_regwrite_q", {31'b0, bus_if.regwrite_q}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // add
    apply(32'h0022_1820, 32'd5, 32'd3);
    chk("add_ctl", ctl(), 32'b100_1000_0010);
    chk("add_aluctl", {28'b0, bus_if.aluctl}, 32'h2);
    chk("add_out", bus_if.alu_out, 32'd8);
    chk("add_zero", {31'b0, bus_if.zero}, 32'h0);
    tick();
    chk("add_out_q", bus_if.alu_out_q, 32'd8);
    chk("add_regwrite_q", {31'b0, bus_if.regwrite_q}, 32'h1);

    // R-type funct sweep
    apply(32'h0022_1822, 32'd3, 32'd5);
    chk("sub_aluctl", {28'b0, bus_if.aluctl}, 32'h6);
    chk("sub_out", bus_if.alu_out, 32'hFFFF_FFFE);
    apply(32'h0022_1824, 32'h0000_F0F0, 32'h0000_FF00);
    chk("and_aluctl", {28'b0, bus_if.aluctl}, 32'h0);
    chk("and_out", bus_if.alu_out, 32'h0000_F000);
    apply(32'h0022_1825, 32'h0000_F0F0, 32'h0000_FF00);
    chk("or_aluctl", {28'b0, bus_if.aluctl}, 32'h1);
    chk("or_out", bus_if.alu_out, 32'h0000_FFF0);
    apply(32'h0022_1826, 32'h0000_F0F0, 32'h0000_FF00);
    chk("xor_aluctl", {28'b0, bus_if.aluctl}, 32'hD);
    chk("xor_out", bus_if.alu_out, 32'h0000_0FF0);
    apply(32'h0022_1827, 32'h0, 32'h0);
    chk("nor_aluctl", {28'b0, bus_if.aluctl}, 32'hC);
    chk("nor_out", bus_if.alu_out, 32'hFFFF_FFFF);
    chk("nor_zero", {31'b0, bus_if.zero}, 32'h0);
    apply(32'h0022_182A, 32'hFFFF_FFFF, 32'd1);
    chk("slt_aluctl", {28'b0, bus_if.aluctl}, 32'h7);
    chk("slt_neg_lt", bus_if.alu_out, 32'd1);
    apply(32'h0022_182A, 32'd1, 32'hFFFF_FFFF);
    chk("slt_swap", bus_if.alu_out, 32'd0);
    chk("slt_swap_zero", {31'b0, bus_if.zero}, 32'h1);
    apply(32'h0022_183F, 32'd1, 32'd2);
    chk("badfn_aluctl", {28'b0, bus_if.aluctl}, 32'h2);
    chk("badfn_out", bus_if.alu_out, 32'd3);

    // branches
    apply(32'h1022_0004, 32'd7, 32'd7);
    chk("beq_ctl", ctl(), 32'b000_0001_0001);
    chk("beq_aluctl", {28'b0, bus_if.aluctl}, 32'h6);
    chk("beq_zero_eq", {31'b0, bus_if.zero}, 32'h1);
    apply(32'h1022_0004, 32'd7, 32'd6);
    chk("beq_zero_ne", {31'b0, bus_if.zero}, 32'h0);
    apply(32'h1422_0004, 32'd7, 32'd6);
    chk("bne_ctl", ctl(), 32'b000_0000_1001);

    // memory and immediate ops
    apply(32'h8C01_0010, 32'h100, 32'hDEAD_BEEF);
    chk("lw_ctl", ctl(), 32'b011_1100_0000);
    chk("lw_aluctl", {28'b0, bus_if.aluctl}, 32'h2);
    chk("lw_out", bus_if.alu_out, 32'h110);
    apply(32'h8C01_FFF0, 32'h100, 32'h0);
    chk("lw_negimm", bus_if.alu_out, 32'h0F0);
    apply(32'hAC01_0008, 32'h20, 32'h0);
    chk("sw_ctl", ctl(), 32'b010_0010_0000);
    chk("sw_out", bus_if.alu_out, 32'h28);
    apply(32'h2001_0005, 32'd10, 32'h0);
    chk("addi_ctl", ctl(), 32'b010_1000_0000);
    chk("addi_out", bus_if.alu_out, 32'd15);
    apply(32'h0800_0010, 32'h0, 32'h0);
    chk("j_ctl", ctl(), 32'b000_0000_0100);

    // NOP and unknown opcode
    apply(32'h0, 32'd1, 32'd2);
    chk("nop_ctl", ctl(), 32'h0);
    chk("nop_aluctl", {28'b0, bus_if.aluctl}, 32'h2);
    apply(32'hFC00_0000, 32'd1, 32'd2);
    chk("unk_ctl", ctl(), 32'h0);

    // register flow: load, hold, flush over hold, reload
    apply(32'h0022_1820, 32'd5, 32'd3);
    tick();
    chk("flow_load", bus_if.alu_out_q, 32'd8);
    apply(32'h8C01_0010, 32'h100, 32'h0);
    bus_if.hold = 1'b1;
    tick();
    chk("hold_out_q", bus_if.alu_out_q, 32'd8);
    chk("hold_regwrite_q", {31'b0, bus_if.regwrite_q}, 32'h1);
    chk("hold_memread_q", {31'b0, bus_if.memread_q}, 32'h0);
    @(negedge clk);
    bus_if.flush = 1'b1;
    tick();
    chk("flush_out_q", bus_if.alu_out_q, 32'h0);
    chk("flush_regwrite_q", {31'b0, bus_if.regwrite_q}, 32'h0);
    @(negedge clk);
    bus_if.flush = 1'b0;
    bus_if.hold  = 1'b0;
    tick();
    chk("lw_out_q", bus_if.alu_out_q, 32'h110);
    chk("lw_memrd_q", {30'b0, bus_if.memread_q, bus_if.memtoreg_q}, 32'h3);
    chk("lw_memwr_q", {31'b0, bus_if.memwrite_q}, 32'h0);
    apply(32'hAC01_0008, 32'h20, 32'h0);
    tick();
    chk("sw_memwr_q", {31'b0, bus_if.memwrite_q}, 32'h1);
    apply(32'h1022_0004, 32'd7, 32'd7);
    tick();
    chk("beq_zero_q", {31'b0, bus_if.zero_q}, 32'h1);

    // async reset mid-cycle, then first edge after release loads
    apply(32'h8C01_0010, 32'h100, 32'h0);
    tick();
    chk("pre_rst_q", bus_if.alu_out_q, 32'h110);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", bus_if.alu_out_q, 32'h0);
    chk("async_rst_rd_q", {31'b0, bus_if.memread_q}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_load", bus_if.alu_out_q, 32'h110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
